// File: rtl/video_timing_if.sv
// Raster timing bundle: position, display enable, syncs, start pulses and
// frame count, all describing the same pixel in any given cycle.
`timescale 1ns/1ps
interface video_timing_if;
  logic [12:0] o_x;
  logic [12:0] o_y;
  logic        o_disp_enable;
  logic        o_hsync;
  logic        o_vsync;
  logic        o_line_start;
  logic        o_frame_start;
  logic [15:0] o_frame_count;

  modport master (
    output o_x, o_y, o_disp_enable, o_hsync, o_vsync,
           o_line_start, o_frame_start, o_frame_count
  );

  modport slave (
    input  o_x, o_y, o_disp_enable, o_hsync, o_vsync,
           o_line_start, o_frame_start, o_frame_count
  );
endinterface

// File: rtl/video_timing.sv
// Raster timing generator. The next raster position is computed
// combinationally, its flags are derived from that next position, and both
// are registered together so every output describes the same pixel.
`timescale 1ns/1ps
module video_timing #(
  parameter int H_RESOLUTION  = 640,
  parameter int H_FRONT_PORCH = 16,
  parameter int H_SYNC        = 96,
  parameter int H_BACK_PORCH  = 48,
  parameter int V_RESOLUTION  = 480,
  parameter int V_FRONT_PORCH = 10,
  parameter int V_SYNC        = 2,
  parameter int V_BACK_PORCH  = 33,
  parameter int H_SYNC_POL    = 0,
  parameter int V_SYNC_POL    = 0
) (
  input  logic           i_clk,
  input  logic           i_reset,
  video_timing_if.master vt
);

  localparam int H_TOTAL = H_RESOLUTION + H_FRONT_PORCH + H_SYNC + H_BACK_PORCH;
  localparam int V_TOTAL = V_RESOLUTION + V_FRONT_PORCH + V_SYNC + V_BACK_PORCH;

  // Bounds are one bit wider than the counters so an end bound of 8192
  // is representable and no comparison truncates.
  localparam logic [13:0] H_LAST   = 14'(H_TOTAL - 1);
  localparam logic [13:0] V_LAST   = 14'(V_TOTAL - 1);
  localparam logic [13:0] H_ACT    = 14'(H_RESOLUTION);
  localparam logic [13:0] V_ACT    = 14'(V_RESOLUTION);
  localparam logic [13:0] HS_BEG   = 14'(H_RESOLUTION + H_FRONT_PORCH);
  localparam logic [13:0] HS_END   = 14'(H_RESOLUTION + H_FRONT_PORCH + H_SYNC);
  localparam logic [13:0] VS_BEG   = 14'(V_RESOLUTION + V_FRONT_PORCH);
  localparam logic [13:0] VS_END   = 14'(V_RESOLUTION + V_FRONT_PORCH + V_SYNC);
  localparam logic        HS_ON    = 1'(H_SYNC_POL);
  localparam logic        VS_ON    = 1'(V_SYNC_POL);

  if (H_TOTAL > 8192 || H_TOTAL < 1) begin : g_bad_h_total
    $error("video_timing: H_TOTAL must be in 1..8192");
  end
  if (V_TOTAL > 8192 || V_TOTAL < 1) begin : g_bad_v_total
    $error("video_timing: V_TOTAL must be in 1..8192");
  end

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state_q, state_nxt;

  logic [12:0] x_p0, y_p0;
  logic [15:0] fc_p0;
  logic        de_p0, hs_p0, vs_p0, ls_p0, fs_p0;

  logic [12:0] x_p1, y_p1;
  logic [15:0] fc_p1;
  logic        de_p1, hs_p1, vs_p1, ls_p1, fs_p1;

  // State register: leave IDLE on the first edge after reset release.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state_q <= IDLE;
    else         state_q <= state_nxt;
  end

  // Next position, frame count and the flags of that next position.
  always_comb begin
    state_nxt = state_q;
    x_p0      = '0;
    y_p0      = '0;
    fc_p0     = '0;
    unique case (state_q)
      IDLE: state_nxt = RUN;
      RUN: begin
        x_p0  = x_p1 + 13'd1;
        y_p0  = y_p1;
        fc_p0 = fc_p1;
        if ({1'b0, x_p1} == H_LAST) begin
          x_p0 = '0;
          if ({1'b0, y_p1} == V_LAST) begin
            y_p0  = '0;
            fc_p0 = fc_p1 + 16'd1;
          end else begin
            y_p0 = y_p1 + 13'd1;
          end
        end
      end
    endcase
    de_p0 = ({1'b0, x_p0} < H_ACT) && ({1'b0, y_p0} < V_ACT);
    hs_p0 = (({1'b0, x_p0} >= HS_BEG) && ({1'b0, x_p0} < HS_END)) ? HS_ON : ~HS_ON;
    vs_p0 = (({1'b0, y_p0} >= VS_BEG) && ({1'b0, y_p0} < VS_END)) ? VS_ON : ~VS_ON;
    ls_p0 = (x_p0 == '0);
    fs_p0 = (x_p0 == '0) && (y_p0 == '0);
  end

  // ---- stage p0 -> p1: output registers, idle values while in reset ----
  // Output registers: load the next position together with its flags.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      x_p1  <= '0;
      y_p1  <= '0;
      fc_p1 <= '0;
      de_p1 <= 1'b0;
      hs_p1 <= ~HS_ON;
      vs_p1 <= ~VS_ON;
      ls_p1 <= 1'b0;
      fs_p1 <= 1'b0;
    end else begin
      x_p1  <= x_p0;
      y_p1  <= y_p0;
      fc_p1 <= fc_p0;
      de_p1 <= de_p0;
      hs_p1 <= hs_p0;
      vs_p1 <= vs_p0;
      ls_p1 <= ls_p0;
      fs_p1 <= fs_p0;
    end
  end

  assign vt.o_x           = x_p1;
  assign vt.o_y           = y_p1;
  assign vt.o_disp_enable = de_p1;
  assign vt.o_hsync       = hs_p1;
  assign vt.o_vsync       = vs_p1;
  assign vt.o_line_start  = ls_p1;
  assign vt.o_frame_start = fs_p1;
  assign vt.o_frame_count = fc_p1;

endmodule

// File: tb/tb_video_timing.sv
// Directed bench for video_timing: default 800x525 timing, a small 8x6
// raster with active-high syncs, and a 1x1 raster that makes every cycle a
// frame start so the frame counter wrap is reachable quickly.
`timescale 1ns/1ps
module tb_video_timing;

  logic i_clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  logic rst_c = 1'b1;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 i_clk = ~i_clk;

  video_timing_if vt_a ();
  video_timing_if vt_b ();
  video_timing_if vt_c ();

  video_timing dut_a (
    .i_clk   (i_clk),
    .i_reset (rst_a),
    .vt      (vt_a)
  );

  video_timing #(
    .H_RESOLUTION (4), .H_FRONT_PORCH (1), .H_SYNC (2), .H_BACK_PORCH (1),
    .V_RESOLUTION (3), .V_FRONT_PORCH (1), .V_SYNC (1), .V_BACK_PORCH (1),
    .H_SYNC_POL   (1), .V_SYNC_POL    (1)
  ) dut_b (
    .i_clk   (i_clk),
    .i_reset (rst_b),
    .vt      (vt_b)
  );

  video_timing #(
    .H_RESOLUTION (1), .H_FRONT_PORCH (0), .H_SYNC (0), .H_BACK_PORCH (0),
    .V_RESOLUTION (1), .V_FRONT_PORCH (0), .V_SYNC (0), .V_BACK_PORCH (0),
    .H_SYNC_POL   (0), .V_SYNC_POL    (0)
  ) dut_c (
    .i_clk   (i_clk),
    .i_reset (rst_c),
    .vt      (vt_c)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Idle values of the default instance (active-low syncs sit high).
  task automatic chk_idle_a(input string where);
    chk({where, " x"},  32'(vt_a.o_x), 0);
    chk({where, " y"},  32'(vt_a.o_y), 0);
    chk({where, " de"}, 32'(vt_a.o_disp_enable), 0);
    chk({where, " hs"}, 32'(vt_a.o_hsync), 1);
    chk({where, " vs"}, 32'(vt_a.o_vsync), 1);
    chk({where, " ls"}, 32'(vt_a.o_line_start), 0);
    chk({where, " fs"}, 32'(vt_a.o_frame_start), 0);
    chk({where, " fc"}, 32'(vt_a.o_frame_count), 0);
  endtask

  // Cycle c after reset release on the default 800x525 raster (c < 420000).
  task automatic chk_cycle_a(input int c);
    int x, y;
    string t;
    x = c % 800;
    y = c / 800;
    t = $sformatf("a c=%0d", c);
    chk({t, " x"},  32'(vt_a.o_x), 32'(x));
    chk({t, " y"},  32'(vt_a.o_y), 32'(y));
    chk({t, " de"}, 32'(vt_a.o_disp_enable), 32'(x < 640 && y < 480));
    chk({t, " hs"}, 32'(vt_a.o_hsync), 32'(!(x >= 656 && x <= 751)));
    chk({t, " vs"}, 32'(vt_a.o_vsync), 32'(!(y == 490 || y == 491)));
    chk({t, " ls"}, 32'(vt_a.o_line_start), 32'(x == 0));
    chk({t, " fs"}, 32'(vt_a.o_frame_start), 32'(c == 0));
    chk({t, " fc"}, 32'(vt_a.o_frame_count), 0);
    chk({t, " de_in_sync"},
        32'(vt_a.o_disp_enable && (!vt_a.o_hsync || !vt_a.o_vsync)), 0);
  endtask

  // Cycle c after reset release on the 8x6 raster, 48 cycles per frame.
  task automatic chk_cycle_b(input int c);
    int x, y;
    string t;
    x = c % 8;
    y = (c / 8) % 6;
    t = $sformatf("b c=%0d", c);
    chk({t, " x"},  32'(vt_b.o_x), 32'(x));
    chk({t, " y"},  32'(vt_b.o_y), 32'(y));
    chk({t, " de"}, 32'(vt_b.o_disp_enable), 32'(x < 4 && y < 3));
    chk({t, " hs"}, 32'(vt_b.o_hsync), 32'(x == 5 || x == 6));
    chk({t, " vs"}, 32'(vt_b.o_vsync), 32'(y == 4));
    chk({t, " ls"}, 32'(vt_b.o_line_start), 32'(x == 0));
    chk({t, " fs"}, 32'(vt_b.o_frame_start), 32'(x == 0 && y == 0));
    chk({t, " fc"}, 32'(vt_b.o_frame_count), 32'((c / 48) % 65536));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Default raster: reset state, then two-plus lines cycle by cycle.
    repeat (5) @(negedge i_clk);
    chk_idle_a("a reset");
    rst_a = 1'b0;
    for (int c = 0; c <= 1900; c++) begin
      @(negedge i_clk);
      chk_cycle_a(c);
    end
    // Now at (300,2): assert reset mid-cycle, outputs must clear before the next edge.
    #2 rst_a = 1'b1;
    #1 chk_idle_a("a async");
    repeat (2) @(negedge i_clk);
    chk_idle_a("a held");
    rst_a = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge i_clk);
      chk_cycle_a(c);
    end

    // Small raster, active-high syncs: idle levels then 60 full frames.
    chk(" b reset x",  32'(vt_b.o_x), 0);
    chk(" b reset y",  32'(vt_b.o_y), 0);
    chk(" b reset de", 32'(vt_b.o_disp_enable), 0);
    chk(" b reset hs", 32'(vt_b.o_hsync), 0);
    chk(" b reset vs", 32'(vt_b.o_vsync), 0);
    chk(" b reset fs", 32'(vt_b.o_frame_start), 0);
    chk(" b reset fc", 32'(vt_b.o_frame_count), 0);
    rst_b = 1'b0;
    for (int c = 0; c < 48 * 60 + 5; c++) begin
      @(negedge i_clk);
      chk_cycle_b(c);
    end

    // 1x1 raster: frame count steps every cycle and wraps 65535 -> 0.
    rst_c = 1'b0;
    for (int c = 0; c < 65540; c++) begin
      @(negedge i_clk);
      if (c == 0) begin
        chk("c first x",  32'(vt_c.o_x), 0);
        chk("c first y",  32'(vt_c.o_y), 0);
        chk("c first de", 32'(vt_c.o_disp_enable), 1);
      end
      chk($sformatf("c c=%0d fc", c), 32'(vt_c.o_frame_count), 32'(c % 65536));
      chk($sformatf("c c=%0d fs", c), 32'(vt_c.o_frame_start), 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/video_timing.md
Name: video_timing

Overview:
- Raster timing generator that sits directly upstream of the test pattern stage.
- Produces the per-pixel coordinate pair (o_x, o_y) and the display-enable strobe that the pattern stage consumes.
- Also produces horizontal and vertical sync, line/frame start pulses and a frame counter for the downstream TMDS/HDMI encoder.
- All outputs are registered and mutually aligned: in any cycle they describe the same raster position.

Parameters:
- H_RESOLUTION, 640, active pixels per line
- H_FRONT_PORCH, 16, pixels after active before hsync
- H_SYNC, 96, hsync width in pixels
- H_BACK_PORCH, 48, pixels after hsync before next line
- V_RESOLUTION, 480, active lines per frame
- V_FRONT_PORCH, 10, lines after active before vsync
- V_SYNC, 2, vsync width in lines
- V_BACK_PORCH, 33, lines after vsync before next frame
- H_SYNC_POL, 0, asserted level of o_hsync (0 = active-low)
- V_SYNC_POL, 0, asserted level of o_vsync (0 = active-low)

Ports:
- i_clk  in  1  pixel clock
- i_reset  in  1  asynchronous, active-high reset
- o_x  out  13  horizontal position, 0..H_TOTAL-1
- o_y  out  13  vertical position, 0..V_TOTAL-1
- o_disp_enable  out  1  high when o_x < H_RESOLUTION and o_y < V_RESOLUTION
- o_hsync  out  1  horizontal sync at H_SYNC_POL when asserted
- o_vsync  out  1  vertical sync at V_SYNC_POL when asserted
- o_line_start  out  1  one-cycle pulse when o_x == 0
- o_frame_start  out  1  one-cycle pulse when o_x == 0 and o_y == 0
- o_frame_count  out  16  number of frame starts since reset, minus 1

Behaviour:
- Derived totals: H_TOTAL = sum of the four H parameters (default 800); V_TOTAL = sum of the four V parameters (default 525). Both totals must be <= 8192; lint or elaboration fails otherwise.
- Clock and reset: one clock, i_clk. i_reset is asynchronous and active-high. All state resets immediately on assertion, with no clock required.
- States: IDLE and RUN.
  - Reset forces IDLE.
  - In IDLE: o_x = 0, o_y = 0, o_disp_enable = 0, o_line_start = 0, o_frame_start = 0, o_frame_count = 0, and o_hsync / o_vsync sit at their deasserted level (~H_SYNC_POL / ~V_SYNC_POL).
  - First rising edge with i_reset low: IDLE -> RUN. Outputs load position (0,0) with o_disp_enable = 1, o_line_start = 1, o_frame_start = 1, o_frame_count = 0.
- Advance in RUN, every edge:
  - If x < H_TOTAL-1: x <= x+1.
  - Otherwise x <= 0, and then: y <= y+1 if y < V_TOTAL-1, else y <= 0.
- Flag derivation: flags are computed from the next (x,y) so they register in the same cycle as the position they describe. There is zero latency between a position on o_x/o_y and its flags.
- hsync: asserted iff H_RESOLUTION+H_FRONT_PORCH <= x < H_RESOLUTION+H_FRONT_PORCH+H_SYNC. Default: x = 656..751.
- vsync: asserted iff V_RESOLUTION+V_FRONT_PORCH <= y < V_RESOLUTION+V_FRONT_PORCH+V_SYNC, for every x of those lines. Edges coincide with x == 0. Default: y = 490..491.
- o_frame_count: increments by 1 on each frame start after the first, i.e. on each transition (H_TOTAL-1, V_TOTAL-1) -> (0,0). Wraps 0xFFFF -> 0x0000 silently.
- Reset mid-frame: immediate return to IDLE values. The restart after release is identical to the one after power-up; there is no partial-frame resume.
- Width rules: counters are 13-bit unsigned. Comparisons use the full 13 bits, with no truncation.
- Downstream interaction: the pattern stage registers its own outputs one cycle after it sees o_x/o_y. Compensating that delay is the responsibility of the downstream stage, not this block.

Test Plan:
- Hold i_reset high for 5 cycles, then deassert -> during reset o_x = 0, o_y = 0, o_disp_enable = 0, o_hsync = 1, o_vsync = 1. First edge after release gives (0,0), o_disp_enable = 1, o_frame_start = 1, o_frame_count = 0.
- Run one line -> o_disp_enable high for x = 0..639 and low for 640..799. o_hsync low exactly for x = 656..751. At x = 799 the next cycle is x = 0, y = 1, with o_line_start = 1 and o_frame_start = 0.
- Run one full frame (420000 cycles) -> after (799,524) comes (0,0) with o_frame_start = 1 and o_frame_count = 1. o_vsync is low exactly on lines 490 and 491, falling at x = 0 of line 490 and rising at x = 0 of line 492. o_disp_enable is low on all lines 480..524.
- Assert i_reset asynchronously at (300,200) mid-cycle -> outputs go to IDLE values before the next edge. After release the sequence restarts at (0,0) with o_frame_count = 0.
- Small configuration: H = 4,1,2,1 (total 8), V = 3,1,1,1 (total 6), H_SYNC_POL = V_SYNC_POL = 1, run 70000 frames -> exhaustive per-cycle match against a reference model. o_hsync is high at x = 5..6, o_vsync is high on y = 4, and o_frame_count wraps 65535 -> 0.
- Continuous-run check over 3 default frames -> o_frame_start period is exactly 420000 cycles. o_line_start period is exactly 800 cycles. No cycle has o_disp_enable = 1 while o_hsync or o_vsync is asserted.
